// File: rtl/reg_cmd_master.sv
// reg_cmd_master
// ---------------------------------------------------------------------------
// Command-sequencing master and the only initiator of the register bank.
// Commands arrive on a valid/ready port and are queued in a small circular
// FIFO. They issue to the bank one at a time. Read data is returned on a
// single-entry valid/ready response slot.
//
// Handshake semantics:
//   Command port : a command is pushed at a rising edge where
//                  cmd_valid & cmd_ready. cmd_ready is !full. While the FIFO
//                  is full, cmd_valid is ignored.
//   Response port: rsp_valid stays high and rsp_data stays stable until an
//                  edge where rsp_valid & rsp_ready. rsp_data keeps its value
//                  until the next read capture.
//   Bank port    : a transfer is accepted at an edge where reg_sel &
//                  reg_ready. A write completes at that edge. For a read, the
//                  data arrives on reg_rdata in the following cycle. The bank
//                  drops reg_ready for that cycle and raises it again only at
//                  an edge where reg_sel is high.
//
// Ports:
//   clk, rstn                   clock, synchronous active-low reset
//   cmd_valid/ready/wr/addr/wdata  command input port
//   rsp_valid/ready/data        read response output port
//   reg_sel/wr/addr/wdata       registered request outputs to the bank
//   reg_rdata, reg_ready        bank read data and ready
//   busy                        FSM not idle or FIFO non-empty
//   fifo_level                  FIFO occupancy
// ---------------------------------------------------------------------------
module reg_cmd_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  reg_sel,
   output logic                  reg_wr,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   input  logic                  reg_ready,
   output logic                  busy,
   output logic [LVL_W-1:0]      fifo_level
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // FIFO entry layout: {wr, addr, wdata}
   localparam int ENT_W = 1 + ADDR_WIDTH + DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RD_WAIT = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                state_q, state_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [ENT_W-1:0]      fifo_mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]      fifo_mem_d [FIFO_DEPTH];
   logic                  reg_sel_q, reg_sel_d;
   logic                  reg_wr_q, reg_wr_d;
   logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

   // ------------------------------------------------------------------
   // FIFO status and head decode
   // ------------------------------------------------------------------
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [ENT_W-1:0]      head;
   logic                  head_wr;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;
   logic                  load_ok;

   assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);
   assign push       = cmd_valid & ~fifo_full;

   assign head       = fifo_mem_q[rd_ptr_q];
   assign head_wr    = head[ENT_W-1];
   assign head_addr  = head[ENT_W-2 -: ADDR_WIDTH];
   assign head_wdata = head[DATA_WIDTH-1:0];

   // A read may only start when the response slot is empty. The slot then
   // cannot be overwritten by the read's capture. Writes produce no
   // response, so a held response never blocks them.
   assign load_ok = ~fifo_empty & (head_wr | ~rsp_valid_q);

   // ------------------------------------------------------------------
   // Sequencer next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      reg_sel_d   = reg_sel_q;
      reg_wr_d    = reg_wr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (load_ok) begin
               pop         = 1'b1;
               state_d     = S_ISSUE;
               reg_sel_d   = 1'b1;
               reg_wr_d    = head_wr;
               reg_addr_d  = head_addr;
               reg_wdata_d = head_wdata;
            end
         end

         S_ISSUE: begin
            // Without reg_ready every issue register simply holds.
            if (reg_ready) begin
               if (reg_wr_q) begin
                  // The write completes at this edge. Chain the next head
                  // directly so back-to-back writes run at one per cycle.
                  if (load_ok) begin
                     pop         = 1'b1;
                     reg_wr_d    = head_wr;
                     reg_addr_d  = head_addr;
                     reg_wdata_d = head_wdata;
                  end else begin
                     state_d   = S_IDLE;
                     reg_sel_d = 1'b0;
                  end
               end else begin
                  // reg_sel stays high through RD_WAIT. The bank re-raises
                  // its ready only at an edge where sel is high.
                  state_d = S_RD_WAIT;
               end
            end
         end

         S_RD_WAIT: begin
            // The bank's read data is valid in exactly this cycle.
            rsp_data_d  = reg_rdata;
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
            reg_sel_d   = 1'b0;
         end

         default: begin
            state_d   = S_IDLE;
            reg_sel_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;

      if (push) begin
         fifo_mem_d[wr_ptr_q] = {cmd_wr, cmd_addr, cmd_wdata};
         // The depth is a power of 2, so the pointers wrap naturally.
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rstn) begin
         // Reset abandons any in-flight read and flushes queued commands.
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
         reg_sel_q   <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         fifo_mem_q  <= fifo_mem_d;
         reg_sel_q   <= reg_sel_d;
         reg_wr_q    <= reg_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign cmd_ready  = ~fifo_full;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign reg_sel    = reg_sel_q;
   assign reg_wr     = reg_wr_q;
   assign reg_addr   = reg_addr_q;
   assign reg_wdata  = reg_wdata_q;
   assign busy       = (state_q != S_IDLE) | ~fifo_empty;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Directed testbench for reg_cmd_master with a behavioural register bank.
module tb_reg_cmd_master;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int DEPTH = 4;
   localparam int LW = $clog2(DEPTH + 1);

   logic          clk;
   logic          rstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_wr;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          reg_sel;
   logic          reg_wr;
   logic [AW-1:0] reg_addr;
   logic [DW-1:0] reg_wdata;
   logic [DW-1:0] reg_rdata;
   logic          reg_ready;
   logic          busy;
   logic [LW-1:0] fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   reg_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
      .busy(busy), .fifo_level(fifo_level)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- register bank model ----------------
   // Every register resets to 16'h1234. A read drops ready for one cycle,
   // and ready comes back only at an edge where sel is high. 'stall' masks
   // ready so the bench can hold a transfer in ISSUE.
   logic [DW-1:0] bank_mem [256];
   logic          bank_rdy_q;
   logic [DW-1:0] bank_rdata_q;
   logic          stall;

   assign reg_ready = bank_rdy_q & ~stall;
   assign reg_rdata = bank_rdata_q;

   always @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < 256; i++) bank_mem[i] <= 16'h1234;
         bank_rdy_q   <= 1'b1;
         bank_rdata_q <= '0;
      end else if (reg_sel && reg_ready) begin
         if (reg_wr) begin
            bank_mem[reg_addr] <= reg_wdata;
         end else begin
            bank_rdata_q <= bank_mem[reg_addr];
            bank_rdy_q   <= 1'b0;
         end
      end else if (reg_sel && !bank_rdy_q) begin
         bank_rdy_q <= 1'b1;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one command until it is accepted; returns just after that edge.
   task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic ok;
      ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
         @(posedge clk);
      end
      #1;
      cmd_valid = 1'b0;
      chk("push_accepted", {31'd0, ok}, 32'd1);
   endtask

   // Wait for a response and check its data. Then hold it for 'hold' cycles
   // to confirm no read issues meanwhile, and finally consume it.
   task automatic take_rsp(input string tag, input logic [DW-1:0] exp, input int hold);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
      end
      chk({tag, "_arrived"}, {31'd0, got}, 32'd1);
      chk({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_held_no_issue"}, {31'd0, reg_sel}, 32'd0);
         chk({tag, "_held_valid"}, {31'd0, rsp_valid}, 32'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; rsp_ready = 1'b0; stall = 1'b0;

      // Reset values
      @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("rst_reg_sel", {31'd0, reg_sel}, 32'd0);
      chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
      chk("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
      chk("rst_reg_wdata", {16'd0, reg_wdata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_reg_sel", {31'd0, reg_sel}, 32'd0);
         chk("idle_busy", {31'd0, busy}, 32'd0);
      end

      // Read after reset: addr 2, pushed at edge N
      @(posedge clk); #1;
      push(1'b0, 8'd2, 16'h0);
      @(negedge clk);                                   // cycle N+1
      chk("rd_n1_sel", {31'd0, reg_sel}, 32'd0);
      chk("rd_n1_level", {29'd0, fifo_level}, 32'd1);
      chk("rd_n1_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);                                   // cycle N+2
      chk("rd_n2_sel", {31'd0, reg_sel}, 32'd1);
      chk("rd_n2_wr", {31'd0, reg_wr}, 32'd0);
      chk("rd_n2_addr", {24'd0, reg_addr}, 32'd2);
      chk("rd_n2_level", {29'd0, fifo_level}, 32'd0);
      @(negedge clk);                                   // cycle N+3 (RD_WAIT)
      chk("rd_n3_sel", {31'd0, reg_sel}, 32'd1);
      chk("rd_n3_bank_ready", {31'd0, reg_ready}, 32'd0);
      chk("rd_n3_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);                                   // cycle N+4
      chk("rd_n4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_n4_rsp_data", {16'd0, rsp_data}, 32'h1234);
      chk("rd_n4_sel", {31'd0, reg_sel}, 32'd0);
      chk("rd_n4_bank_ready", {31'd0, reg_ready}, 32'd1);
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("rd_consumed_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rd_consumed_data_hold", {16'd0, rsp_data}, 32'h1234);

      // Write then read-back: W at N, R at N+1
      @(posedge clk); #1;
      push(1'b1, 8'd1, 16'hBEEF);
      push(1'b0, 8'd1, 16'h0);
      @(negedge clk);                                   // cycle N+2
      chk("wr_sel", {31'd0, reg_sel}, 32'd1);
      chk("wr_wr", {31'd0, reg_wr}, 32'd1);
      chk("wr_addr", {24'd0, reg_addr}, 32'd1);
      chk("wr_wdata", {16'd0, reg_wdata}, 32'hBEEF);
      chk("wr_level", {29'd0, fifo_level}, 32'd1);
      @(negedge clk);                                   // cycle N+3
      chk("rb_issue_sel", {31'd0, reg_sel}, 32'd1);
      chk("rb_issue_wr", {31'd0, reg_wr}, 32'd0);
      chk("rb_issue_level", {29'd0, fifo_level}, 32'd0);
      @(negedge clk);                                   // cycle N+4 (RD_WAIT)
      chk("rb_wait_sel", {31'd0, reg_sel}, 32'd1);
      chk("rb_wait_bank_ready", {31'd0, reg_ready}, 32'd0);
      @(negedge clk);                                   // cycle N+5
      chk("rb_bank_ready_back", {31'd0, reg_ready}, 32'd1);
      chk("rb_sel_low", {31'd0, reg_sel}, 32'd0);
      take_rsp("rb", 16'hBEEF, 0);

      // FIFO fill and drain: the read is stuck in ISSUE while the bank stalls
      stall = 1'b1;
      push(1'b0, 8'd2, 16'h0);
      push(1'b1, 8'd0, 16'hA0A0);
      push(1'b1, 8'd1, 16'hA1A1);
      push(1'b1, 8'd2, 16'hA2A2);
      push(1'b1, 8'd3, 16'hA3A3);
      @(negedge clk);
      chk("fill_level4", {29'd0, fifo_level}, 32'd4);
      chk("fill_cmd_ready0", {31'd0, cmd_ready}, 32'd0);
      chk("fill_read_in_issue", {31'd0, reg_sel}, 32'd1);
      chk("fill_read_addr", {24'd0, reg_addr}, 32'd2);
      // Offer a command while full: it must be ignored.
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'd7; cmd_wdata = 16'hDEAD;
      @(negedge clk);
      chk("full_ignore_level", {29'd0, fifo_level}, 32'd4);
      chk("full_ignore_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      chk("full_ignore_level2", {29'd0, fifo_level}, 32'd4);
      cmd_valid = 1'b0;
      stall = 1'b0;                                     // bank accepts at edge A
      @(negedge clk);                                   // A+1 RD_WAIT
      chk("drain_rdwait_sel", {31'd0, reg_sel}, 32'd1);
      chk("drain_rdwait_level", {29'd0, fifo_level}, 32'd4);
      @(negedge clk);                                   // A+2 IDLE, response held
      chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("drain_rsp_data", {16'd0, rsp_data}, 32'h1234);
      chk("drain_idle_sel", {31'd0, reg_sel}, 32'd0);
      @(negedge clk);                                   // A+3 ISSUE W0
      chk("drain_w0_addr", {24'd0, reg_addr}, 32'd0);
      chk("drain_w0_data", {16'd0, reg_wdata}, 32'hA0A0);
      chk("drain_w0_level", {29'd0, fifo_level}, 32'd3);
      chk("drain_w0_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      // Push while popping at level DEPTH-1
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'd6; cmd_wdata = 16'h6666;
      @(negedge clk);                                   // A+4 ISSUE W1
      cmd_valid = 1'b0;
      chk("pushpop_level", {29'd0, fifo_level}, 32'd3);
      chk("drain_w1_addr", {24'd0, reg_addr}, 32'd1);
      chk("drain_w1_sel", {31'd0, reg_sel}, 32'd1);
      @(negedge clk);                                   // A+5
      chk("drain_w2_addr", {24'd0, reg_addr}, 32'd2);
      chk("drain_w2_level", {29'd0, fifo_level}, 32'd2);
      @(negedge clk);                                   // A+6
      chk("drain_w3_addr", {24'd0, reg_addr}, 32'd3);
      chk("drain_w3_level", {29'd0, fifo_level}, 32'd1);
      @(negedge clk);                                   // A+7
      chk("drain_w6_addr", {24'd0, reg_addr}, 32'd6);
      chk("drain_w6_data", {16'd0, reg_wdata}, 32'h6666);
      chk("drain_w6_level", {29'd0, fifo_level}, 32'd0);
      chk("drain_still_held", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);                                   // A+8
      chk("drain_done_sel", {31'd0, reg_sel}, 32'd0);
      chk("drain_done_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      take_rsp("drain", 16'h1234, 0);

      // Held response blocks reads, with pointer wrap
      push(1'b0, 8'd0, 16'h0);
      push(1'b0, 8'd1, 16'h0);
      push(1'b0, 8'd2, 16'h0);
      push(1'b0, 8'd3, 16'h0);
      push(1'b1, 8'd5, 16'h5555);
      @(negedge clk);
      chk("hold_level4", {29'd0, fifo_level}, 32'd4);
      chk("hold_cmd_ready0", {31'd0, cmd_ready}, 32'd0);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      take_rsp("r0", 16'hA0A0, 3);
      take_rsp("r1", 16'hA1A1, 3);
      take_rsp("r2", 16'hA2A2, 2);
      take_rsp("r3", 16'hA3A3, 0);
      push(1'b0, 8'd5, 16'h0);
      take_rsp("r5", 16'h5555, 0);
      push(1'b0, 8'd7, 16'h0);
      take_rsp("r7_not_overwritten", 16'h1234, 0);

      // Reset mid-read
      repeat (2) @(posedge clk);
      #1;
      push(1'b0, 8'd0, 16'h0);
      push(1'b1, 8'd7, 16'h7777);
      @(negedge clk);                                   // N+2 ISSUE
      chk("mid_issue_sel", {31'd0, reg_sel}, 32'd1);
      @(negedge clk);                                   // N+3 RD_WAIT
      chk("mid_rdwait_bank_ready", {31'd0, reg_ready}, 32'd0);
      chk("mid_rdwait_level", {29'd0, fifo_level}, 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_sel", {31'd0, reg_sel}, 32'd0);
      chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_no_issue", {31'd0, reg_sel}, 32'd0);
         chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      push(1'b0, 8'd0, 16'h0);
      take_rsp("post_rst_read", 16'h1234, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_cmd_master.md
# reg_cmd_master

Command-sequencing master that sits directly upstream of the register bank and is its only initiator. It buffers read/write commands from a valid/ready command port in a small FIFO and issues them one at a time on the register-bank protocol. That protocol has three rules: writes complete in one accepting cycle, read data returns one cycle after acceptance, and the bank's `ready` drops for that cycle. The master returns read data on a single-entry valid/ready response port.

## Interface
- `ADDR_WIDTH`, 8: register address width; must match the register bank.
- `DATA_WIDTH`, 16: data width; must match the register bank.
- `FIFO_DEPTH`, 4: command FIFO entries; power of 2, minimum 2.
- `LVL_W`, `$clog2(FIFO_DEPTH+1)`: derived localparam; width of `fifo_level`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  target register address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read response held.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  DATA_WIDTH  read data.
- `reg_sel`  out  1  select to the register bank.
- `reg_wr`  out  1  write/read qualifier to the bank.
- `reg_addr`  out  ADDR_WIDTH  address to the bank.
- `reg_wdata`  out  DATA_WIDTH  write data to the bank.
- `reg_rdata`  in  DATA_WIDTH  bank read data; valid only in the cycle after a read is accepted.
- `reg_ready`  in  1  bank ready; a transfer is accepted at an edge where `reg_sel & reg_ready` is true.
- `busy`  out  1  state != IDLE, or FIFO non-empty.
- `fifo_level`  out  LVL_W  FIFO occupancy.

## Operation
- **Command FIFO**
  - Circular buffer with read/write pointers; pointers wrap modulo FIFO_DEPTH.
  - Push when `cmd_valid & cmd_ready`.
  - Push and pop in the same cycle leave the level unchanged.
  - No bypass: a command enters the FIFO before it can issue.
  - When full, `cmd_ready`=0 and `cmd_valid` is ignored.
- **FSM states:** IDLE, ISSUE, RD_WAIT. Bus outputs are registered; `reg_sel`=1 only in ISSUE and RD_WAIT.
- **IDLE**
  - Load condition: FIFO non-empty, and either the head is a write or `rsp_valid`=0.
  - When the load condition holds: pop the head into the issue registers (`reg_addr`, `reg_wr`, `reg_wdata`) and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (`reg_sel`=1)
  - If `reg_ready`=0: hold all outputs and stay.
  - If `reg_ready`=1 and write: the write completes at this edge. If the load condition holds, load the next head and stay in ISSUE (back-to-back writes, one per cycle); otherwise go to IDLE.
  - If `reg_ready`=1 and read: go to RD_WAIT.
- **RD_WAIT** (`reg_sel`=1, `reg_wr`=0, address held)
  - `reg_sel` stays high because the bank re-raises `ready` only at an edge where `sel` is high.
  - At the edge ending this cycle: capture `reg_rdata` into `rsp_data`, set `rsp_valid`=1, go to IDLE.
  - This state always lasts exactly one cycle.
- **Response slot**
  - `rsp_valid` clears at an edge where `rsp_valid & rsp_ready`.
  - `rsp_data` holds its value until the next capture.
  - Writes produce no response.
- **Reset**: all state above resets regardless of the current operation. An in-flight read is abandoned and no response is produced; queued commands are flushed.

## Timing
- Reset values:
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0.
  - `reg_sel`=0, `reg_wr`=0, `reg_addr`=0, `reg_wdata`=0.
  - `busy`=0, `fifo_level`=0; state IDLE; pointers 0.
- Read into an empty FIFO, with the bank ready, pushed at edge N:
  - IDLE loads at edge N+1.
  - ISSUE (`reg_sel`=1) in cycle N+2; the bank accepts at edge N+2.
  - RD_WAIT in cycle N+3; capture at edge N+3.
  - `rsp_valid`=1 in cycle N+4.
- Write pushed at edge N: `reg_sel` high in cycle N+2; the bank is updated at edge N+2.
- A read is never issued while `rsp_valid`=1 and `rsp_ready`=0; the FIFO keeps accepting until full.
- After RD_WAIT, the next transfer cannot start earlier than 2 cycles later (IDLE load, then ISSUE).
- Boundaries:
  - Full with `cmd_valid`=1: no push, and no data is overwritten.
  - Pointer wrap after FIFO_DEPTH pushes: order is preserved.
  - Simultaneous pop and push when `fifo_level`=FIFO_DEPTH-1: level is unchanged.

## Test plan
- **Reset values:** apply reset for 2 cycles, then release. Required: all reset values above; `reg_sel`=0 while the FIFO stays empty.
- **Read after reset:** push read addr 2. Required: `reg_sel` in cycle N+2, `rsp_valid` in cycle N+4, `rsp_data`=16'h1234 (bank reset value).
- **Write then read-back:** push write addr 1 = 16'hBEEF, then read addr 1. Required: `rsp_data`=16'hBEEF. Check that `reg_sel` stays high through RD_WAIT and `reg_ready` returns high afterwards.
- **FIFO fill and drain:** with `rsp_ready`=0, push 1 read + 4 writes. Required: the read issues and its response is held; the 4 writes then issue back-to-back one per cycle and drain while the response is still held. Check the `fifo_level` progression and that `cmd_ready` drops only when `fifo_level`=4.
- **Held response blocks reads:** push reads to addrs 0,1,2,3, mixed with `rsp_ready` stalls and pointer wrap. Required: responses in order; no read issues while `rsp_valid`=1 and `rsp_ready`=0.
- **Reset mid-read:** assert `rstn`=0 during RD_WAIT. Required: `rsp_valid` stays 0, FIFO empty, `reg_sel`=0 the cycle after reset.
